// File: rtl/psum_accum_3x3.sv
// -----------------------------------------------------------------------------
// psum_accum_3x3
//
// Output-side consumer of the 3x3 adder tree. Accumulates the 2-stage-pipelined
// psum_3x3 stream over the input channels of one output pixel, seeded with a
// bias. Each finished sum is requantized (round half up, arithmetic shift,
// saturate) to OUT_W bits and offered downstream on a valid/ready handshake.
// The block also drives the tree's pipe_en, so downstream backpressure freezes
// the whole systolic column.
//
// Build option:
//   PSUM_ACCUM_RELU_EN  when defined, the requantized value is clamped to a
//                       minimum of 0 before saturation (ReLU). Accumulation is
//                       unaffected.
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset
//   cfg_ic_num  psums per output pixel (0 behaves as 1)
//   cfg_bias    signed accumulator seed
//   cfg_shift   arithmetic right shift used by requantization (0..31)
//   in_valid    product valid entering the tree this cycle (qualified by pipe_en)
//   pipe_en     tree pipeline enable / upstream ready
//   psum_3x3    signed psum from the tree's second pipeline register
//   out_valid   result valid
//   out_ready   downstream ready
//   out_data    signed requantized result
//   busy        group in progress or data in flight
//
// cfg_* are not latched; they must stay stable while busy is high.
// -----------------------------------------------------------------------------
module psum_accum_3x3 #(
  parameter int PSUM_W = 32,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 10,
  parameter int OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic        [CNT_W-1:0]  cfg_ic_num,
  input  logic signed [ACC_W-1:0]  cfg_bias,
  input  logic        [4:0]        cfg_shift,
  input  logic                     in_valid,
  output logic                     pipe_en,
  input  logic signed [PSUM_W-1:0] psum_3x3,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     busy
);

  // Requantization runs one bit wider than the accumulator so the rounding
  // constant can never overflow the sum.
  localparam int RW = ACC_W + 1;

  localparam logic signed [RW-1:0] Q_MAX = (RW'(1) <<< (OUT_W - 1)) - RW'(1);
  localparam logic signed [RW-1:0] Q_MIN = -Q_MAX - RW'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                    v1;   // valid alongside the tree's first register
  logic                    v2;   // valid alongside psum_3x3
  logic        [CNT_W-1:0] cnt;  // psums already folded into acc this group
  logic signed [ACC_W-1:0] acc;

  // ---------------------------------------------------------------------------
  // Handshake and consume qualification
  // ---------------------------------------------------------------------------
  logic stall;
  logic consume;
  logic group_end;
  logic [CNT_W-1:0] ic_last;

  // A stalled result freezes the tree; the psum sitting in its last register
  // is consumed only on the edge where it actually advances, so it is never
  // counted twice.
  assign stall   = out_valid & ~out_ready;
  assign pipe_en = ~stall;
  assign consume = v2 & pipe_en;

  // cfg_ic_num == 0 behaves as a single-channel group.
  assign ic_last   = (cfg_ic_num == '0) ? '0 : cfg_ic_num - CNT_W'(1);
  assign group_end = consume & (cnt == ic_last);

  assign busy = v1 | v2 | (cnt != '0) | out_valid;

  // ---------------------------------------------------------------------------
  // Accumulate: the first psum of a group is added to the bias instead of acc.
  // Sum wraps modulo 2^ACC_W.
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] psum_ext;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_next;

  assign psum_ext = ACC_W'(psum_3x3);          // sign-extend or truncate
  assign acc_base = (cnt == '0) ? cfg_bias : acc;
  assign acc_next = acc_base + psum_ext;

  // ---------------------------------------------------------------------------
  // Requantize acc_next: round half up, arithmetic shift, optional ReLU,
  // saturate to the signed OUT_W range.
  // ---------------------------------------------------------------------------
  logic signed [RW-1:0]    rnd_add;
  logic signed [RW-1:0]    r_val;
  logic signed [RW-1:0]    q_val;
  logic signed [OUT_W-1:0] out_next;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    rnd_add = '0;
    if (cfg_shift != 5'd0) begin
      rnd_add = RW'(1) <<< (cfg_shift - 5'd1);
    end

    r_val = RW'(acc_next) + rnd_add;
    q_val = r_val >>> cfg_shift;

`ifdef PSUM_ACCUM_RELU_EN
    if (q_val < 0) begin
      q_val = '0;
    end
`endif

    out_next = q_val[OUT_W-1:0];
    if (q_val > Q_MAX) begin
      out_next = OUT_W'(Q_MAX);
    end else if (q_val < Q_MIN) begin
      out_next = OUT_W'(Q_MIN);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values, matching the hardware.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Partial sums and any unaccepted result are dropped on reset.
      v1        <= 1'b0;
      v2        <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      // Valid shadow of the tree pipeline; holds while the tree is frozen.
      if (pipe_en) begin
        v1 <= in_valid;
        v2 <= v1;
      end

      if (consume) begin
        acc <= acc_next;
        if (group_end) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      // A load can coincide with a handshake (stall is 0 then); the new
      // result simply replaces the accepted one and out_valid stays high.
      if (group_end) begin
        out_valid <= 1'b1;
        out_data  <= out_next;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_psum_accum_3x3.sv
module tb_psum_accum_3x3;

  logic               clk;
  logic               rst_n;
  logic [9:0]         cfg_ic_num;
  logic signed [31:0] cfg_bias;
  logic [4:0]         cfg_shift;
  logic               in_valid;
  logic               pipe_en;
  logic signed [31:0] psum_3x3;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;
  logic               busy;

  // Stand-in for the adder tree: two registers advanced by pipe_en.
  logic signed [31:0] prod;
  logic signed [31:0] p1;
  logic signed [31:0] p2;

  int checks = 0;
  int errors = 0;

  // Results accepted downstream, in order.
  logic signed [7:0] got[$];

  psum_accum_3x3 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_ic_num (cfg_ic_num),
    .cfg_bias   (cfg_bias),
    .cfg_shift  (cfg_shift),
    .in_valid   (in_valid),
    .pipe_en    (pipe_en),
    .psum_3x3   (psum_3x3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pipe_en) begin
      p1 <= prod;
      p2 <= p1;
    end
  end
  assign psum_3x3 = p2;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back(out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one product and hold it until the tree accepts it.
  task automatic push(input logic signed [31:0] v);
    logic ok;
    int   n;
    n = 0;
    in_valid = 1'b1;
    prod     = v;
    do begin
      ok = pipe_en;
      tick();
      n++;
    end while (!ok && n < 100);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: product %0d not accepted within 100 cycles", v);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    prod     = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: busy still %0b after 200 cycles", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_data !== 8'sd0) begin errors++; $display("FAIL rst_out_data: got %0d want 0", out_data); end
    checks++;
    if (pipe_en !== 1'b1) begin errors++; $display("FAIL rst_pipe_en: got %b want 1", pipe_en); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    tick();
  endtask

  // ic=3, bias=10: 10+5-3+100 = 112, visible 3 edges after the last in_valid.
  task automatic test_basic();
    got.delete();
    cfg_ic_num = 10'd3; cfg_bias = 32'sd10; cfg_shift = 5'd0; out_ready = 1'b1;
    push(32'sd5);
    push(-32'sd3);
    push(32'sd100);        // sampled at edge E3
    idle();
    tick();                // E4
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early: out_valid %b after 1 edge, want 0", out_valid); end
    tick();                // E5
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid %b after 2 edges, want 1", out_valid); end
    checks++;
    if (out_data !== 8'sd112) begin errors++; $display("FAIL basic_data: got %0d want 112", out_data); end
    tick();                // E6: handshake
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: out_valid %b want 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: busy %b want 0", busy); end
    tick();
    checks++;
    if (got.size() != 1) begin errors++; $display("FAIL basic_count: got %0d results want 1", got.size()); end
  endtask

  task automatic test_saturate();
    logic signed [7:0] exp_q[$];
`ifdef PSUM_ACCUM_RELU_EN
    exp_q = '{8'sd127, 8'sd0};
`else
    exp_q = '{8'sd127, -8'sd128};
`endif
    got.delete();
    cfg_ic_num = 10'd1; cfg_bias = 32'sd0; cfg_shift = 5'd0; out_ready = 1'b1;
    push(32'sd200);
    push(-32'sd300);
    idle();
    drain();
    checks++;
    if (got.size() != exp_q.size()) begin errors++; $display("FAIL sat_count: got %0d results want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL sat_data[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
    end
  endtask

  // shift=2: (7+2)>>2=2, (-7+2)>>>2=-2, (6+2)>>2=2.
  task automatic test_rounding();
    logic signed [7:0] exp_q[$];
`ifdef PSUM_ACCUM_RELU_EN
    exp_q = '{8'sd2, 8'sd0, 8'sd2};
`else
    exp_q = '{8'sd2, -8'sd2, 8'sd2};
`endif
    got.delete();
    cfg_ic_num = 10'd1; cfg_bias = 32'sd0; cfg_shift = 5'd2; out_ready = 1'b1;
    push(32'sd7);
    push(-32'sd7);
    push(32'sd6);
    idle();
    drain();
    checks++;
    if (got.size() != exp_q.size()) begin errors++; $display("FAIL round_count: got %0d results want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL round_data[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [7:0] exp_q[$];
    exp_q = '{8'sd1, 8'sd2, 8'sd3};
    got.delete();
    cfg_ic_num = 10'd1; cfg_bias = 32'sd0; cfg_shift = 5'd0; out_ready = 1'b0;
    push(32'sd1);
    push(32'sd2);
    push(32'sd3);
    idle();
    tick();
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    checks++;
    if (out_data !== 8'sd1) begin errors++; $display("FAIL bp_hold: got %0d want 1", out_data); end
    checks++;
    if (pipe_en !== 1'b0) begin errors++; $display("FAIL bp_pipe_en: got %b want 0", pipe_en); end
    checks++;
    if (psum_3x3 !== 32'sd2) begin errors++; $display("FAIL bp_frozen: psum_3x3 %0d want 2", psum_3x3); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b want 1", busy); end
    tick();
    out_ready = 1'b1;
    drain();
    checks++;
    if (got.size() != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d results want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_ic_zero();
    logic signed [7:0] exp_q[$];
    exp_q = '{8'sd4, 8'sd9};
    got.delete();
    cfg_ic_num = 10'd0; cfg_bias = 32'sd0; cfg_shift = 5'd0; out_ready = 1'b1;
    push(32'sd4);
    push(32'sd9);
    idle();
    drain();
    checks++;
    if (got.size() != exp_q.size()) begin errors++; $display("FAIL ic0_count: got %0d results want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL ic0_data[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    got.delete();
    cfg_ic_num = 10'd4; cfg_bias = 32'sd0; cfg_shift = 5'd0; out_ready = 1'b1;
    push(32'sd1);
    push(32'sd1);
    idle();
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    tick();
    for (int i = 0; i < 4; i++) push(32'sd1);
    idle();
    drain();
    checks++;
    if (got.size() != 1) begin errors++; $display("FAIL mid_count: got %0d results want 1", got.size()); end
    else begin
      checks++;
      if (got[0] !== 8'sd4) begin errors++; $display("FAIL mid_data: got %0d want 4", got[0]); end
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_ic_num = '0; cfg_bias = '0; cfg_shift = '0;
    in_valid = 1'b0; prod = '0; out_ready = 1'b1;
    p1 = '0; p2 = '0;
    test_reset();
    test_basic();
    test_saturate();
    test_rounding();
    test_back_to_back();
    test_ic_zero();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
